// File: rtl/tap_delay_line.sv
// ---------------------------------------------------------------------------
// tap_delay_line
//
// Multi-channel tapped delay line. Each of NUM_CH interleaved channels keeps
// its own NUM_TAPS-deep sample history and a saturating fill counter. An
// accepted sample shifts into its channel's history. One cycle later the
// block presents a registered snapshot of that channel's whole history.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset (highest priority)
//   in_valid    in   qualifies in_ch / in_data for one cycle
//   in_ch       in   channel index of the incoming sample (ignored if NUM_CH=1)
//   in_data     in   raw sample
//   flush       in   clears every channel's history (priority over in_valid)
//   out_valid   out  one-cycle pulse marking a fresh snapshot
//   out_ch      out  channel of the current snapshot
//   taps        out  snapshot; tap k at [k*DATA_WIDTH +: DATA_WIDTH], tap 0 newest
//   fill_count  out  valid samples held for out_ch, saturating at NUM_TAPS
//   full        out  fill_count == NUM_TAPS
//   ch_err      out  one-cycle pulse after a sample to a nonexistent channel
//
// All outputs are registered, so there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module tap_delay_line #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_TAPS   = 8,
    parameter  int NUM_CH     = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W      = $clog2(NUM_TAPS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [CH_W-1:0]                in_ch,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           flush,
    output logic                           out_valid,
    output logic [CH_W-1:0]                out_ch,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] taps,
    output logic [CNT_W-1:0]               fill_count,
    output logic                           full,
    output logic                           ch_err
);

    localparam int HIST_W = NUM_TAPS * DATA_WIDTH;

    // Per-channel state.
    logic [NUM_CH-1:0][HIST_W-1:0] hist_q, hist_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q,  cnt_d;

    // Registered outputs.
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
    logic [HIST_W-1:0] taps_q,      taps_d;
    logic [CNT_W-1:0]  fill_q,      fill_d;
    logic              full_q,      full_d;
    logic              ch_err_q,    ch_err_d;

    // Channel decode. A single-channel build ignores in_ch entirely.
    logic [CH_W-1:0]   ch_sel;
    logic              ch_ok;
    logic              accept;
    logic              drop_bad;
    logic [HIST_W-1:0] hist_sel;
    logic [HIST_W-1:0] hist_shift;
    logic [CNT_W-1:0]  cnt_cur;
    logic [CNT_W-1:0]  cnt_next;

    assign ch_sel   = (NUM_CH == 1) ? '0 : in_ch;
    assign ch_ok    = (NUM_CH == 1) || (32'(in_ch) < 32'(NUM_CH));
    assign accept   = in_valid && ch_ok && !flush;
    assign drop_bad = in_valid && !ch_ok && !flush;

    // History of the addressed channel. The index is only meaningful when ch_ok.
    assign hist_sel = hist_q[ch_sel];
    assign cnt_cur  = cnt_q[ch_sel];

    // Shift toward older taps: the newest sample enters at tap 0 (LSBs) and the
    // oldest tap falls off the top.
    assign hist_shift = {hist_sel[HIST_W-DATA_WIDTH-1:0], in_data};

    // The fill counter saturates rather than wrapping, so it stays at NUM_TAPS.
    assign cnt_next = (cnt_cur == CNT_W'(NUM_TAPS)) ? cnt_cur : cnt_cur + CNT_W'(1);

    always_comb begin
        hist_d      = hist_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        ch_err_d    = 1'b0;
        out_ch_d    = out_ch_q;
        taps_d      = taps_q;
        fill_d      = fill_q;
        full_d      = full_q;

        if (flush) begin
            // Flush wipes all history and the visible snapshot. A sample
            // presented in the same cycle is lost and raises no error.
            hist_d = '0;
            cnt_d  = '0;
            taps_d = '0;
            fill_d = '0;
            full_d = 1'b0;
        end else if (accept) begin
            hist_d[ch_sel] = hist_shift;
            cnt_d[ch_sel]  = cnt_next;
            out_valid_d    = 1'b1;
            out_ch_d       = ch_sel;
            taps_d         = hist_shift;
            fill_d         = cnt_next;
            full_d         = (cnt_next == CNT_W'(NUM_TAPS));
        end else if (drop_bad) begin
            ch_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            taps_q      <= '0;
            fill_q      <= '0;
            full_q      <= 1'b0;
            ch_err_q    <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            taps_q      <= taps_d;
            fill_q      <= fill_d;
            full_q      <= full_d;
            ch_err_q    <= ch_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign taps       = taps_q;
    assign fill_count = fill_q;
    assign full       = full_q;
    assign ch_err     = ch_err_q;

endmodule
